// File: rtl/rot_debounce_if.sv
// Raw and debounced rotary-encoder signals between the encoder pins and the debouncer.
// The master drives the raw pins; the slave (rot_debounce) returns the clean levels and strobes.
interface rot_debounce_if;
    logic ROT_A_IN;
    logic ROT_B_IN;
    logic ROT_CTR_IN;
    logic ROT_A;
    logic ROT_B;
    logic ROT_CTR;
    logic CTR_PRESS;
    logic CTR_RELEASE;

    modport master (
        output ROT_A_IN, ROT_B_IN, ROT_CTR_IN,
        input  ROT_A, ROT_B, ROT_CTR, CTR_PRESS, CTR_RELEASE
    );

    modport slave (
        input  ROT_A_IN, ROT_B_IN, ROT_CTR_IN,
        output ROT_A, ROT_B, ROT_CTR, CTR_PRESS, CTR_RELEASE
    );
endinterface

// File: rtl/rot_debounce.sv
// Rotary encoder debouncer: per-channel 2-flop synchronizer plus stable-count filter.
// Define ROT_DEBOUNCE_STROBE_EN to generate the CTR_PRESS / CTR_RELEASE strobes.
module rot_debounce #(
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = 16
) (
    input  logic          C_CLK,
    input  logic          RST_N,
    rot_debounce_if.slave bus
);
    // Channel order in every vector: [0]=A, [1]=B, [2]=CTR. A/B idle high at the detent.
    localparam logic [2:0]       RST_LVL = 3'b011;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    if ((DB_CYCLES < 2) || (longint'(DB_CYCLES) > (longint'(1) << CNT_W))) begin : g_bad_db_cycles
        $error("rot_debounce: DB_CYCLES=%0d outside 2..2**CNT_W (CNT_W=%0d)", DB_CYCLES, CNT_W);
    end

    logic [2:0]            sync1_q, sync1_d;
    logic [2:0]            sync2_q, sync2_d;
    logic [2:0]            clean_q, clean_d;
    logic [2:0][CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        sync1_d = {bus.ROT_CTR_IN, bus.ROT_B_IN, bus.ROT_A_IN};
        sync2_d = sync1_q;
        clean_d = clean_q;
        cnt_d   = cnt_q;
        for (int ch = 0; ch < 3; ch++) begin
            if (sync2_q[ch] == clean_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_MAX) begin
                clean_d[ch] = sync2_q[ch];
                cnt_d[ch]   = '0;
            end else begin
                cnt_d[ch] = cnt_q[ch] + 1'b1;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge C_CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= RST_LVL;
            sync2_q <= RST_LVL;
            clean_q <= RST_LVL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ROT_A   = clean_q[0];
    assign bus.ROT_B   = clean_q[1];
    assign bus.ROT_CTR = clean_q[2];

`ifdef ROT_DEBOUNCE_STROBE_EN
    logic prev_q, prev_d;

    always_comb prev_d = clean_q[2];

    always_ff @(posedge C_CLK or negedge RST_N) begin
        if (!RST_N) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    // Press and release are mutually exclusive: they need opposite clean levels.
    assign bus.CTR_PRESS   =  clean_q[2] & ~prev_q;
    assign bus.CTR_RELEASE = ~clean_q[2] &  prev_q;
`else
    assign bus.CTR_PRESS   = 1'b0;
    assign bus.CTR_RELEASE = 1'b0;
`endif
endmodule

// File: doc/rot_debounce.md
ROT_DEBOUNCE -- requirements
Module: rot_debounce

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 50000, number of consecutive stable cycles required to accept a new level (1 ms at 50 MHz).
REQ-002 SHALL have parameter CNT_W, default 16, width of each debounce counter.
REQ-003 SHALL have port C_CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports ROT_A_IN, ROT_B_IN, ROT_CTR_IN  input  1 each  raw, asynchronous encoder A, B and push-button levels.
REQ-006 SHALL have ports ROT_A, ROT_B, ROT_CTR  output  1 each  debounced levels feeding the quadrature decoder.
REQ-007 SHALL have ports CTR_PRESS, CTR_RELEASE  output  1 each  single-cycle strobes on debounced button press and release.

Function
REQ-008 SHALL pass each raw input through an independent two-flop synchronizer (sync1, then sync2) before any other use.
REQ-009 SHALL keep one CNT_W-bit counter per channel; channels SHALL be fully independent.
REQ-010 On each edge, per channel: if sync2 equals the clean output, counter <= 0; else if counter == DB_CYCLES-1, clean output <= sync2 and counter <= 0; else counter <= counter+1.
REQ-011 Latency: for a level held stable, the clean output SHALL change on the (DB_CYCLES+2)th rising edge, counting the first edge that samples the new raw level as edge 1.
REQ-012 A raw excursion that reaches sync2 for fewer than DB_CYCLES consecutive cycles SHALL NOT change the clean output, and the counter SHALL return to 0 when sync2 matches again.
REQ-013 CTR_PRESS SHALL be high for exactly the one cycle in which clean ROT_CTR is 1 and its previous-cycle value was 0.
REQ-014 CTR_RELEASE SHALL be high for exactly the one cycle in which clean ROT_CTR is 0 and its previous-cycle value was 1.
REQ-015 CTR_PRESS and CTR_RELEASE SHALL never be high in the same cycle.
REQ-016 Simultaneous transitions on several channels SHALL be debounced concurrently; outputs SHALL update on the same edge when the raw changes were sampled on the same edge.
REQ-017 Counter SHALL never exceed DB_CYCLES-1; no wrap-around SHALL occur.
REQ-018 DB_CYCLES SHALL be in the range 2..2^CNT_W; values outside this range are illegal, and simulation SHALL report an error at elaboration.

Reset
REQ-019 While RST_N is 0, ROT_A, ROT_B and their synchronizer flops SHALL be 1 (detent idle, matching decoder reset state 11).
REQ-020 While RST_N is 0, ROT_CTR and its synchronizer flops SHALL be 0, and all counters and the previous-value flag SHALL be 0.
REQ-021 While RST_N is 0, CTR_PRESS and CTR_RELEASE SHALL be 0.
REQ-022 Reset asserted mid-count SHALL discard all partial counts; the first acceptance after release SHALL require a full DB_CYCLES+2 edges.
REQ-023 Release of RST_N with the raw button held SHALL produce exactly one CTR_PRESS after the REQ-011 latency.

Configuration
REQ-024 Macro ROT_DEBOUNCE_STROBE_EN defined: CTR_PRESS and CTR_RELEASE SHALL be generated per REQ-013..015.
REQ-025 Macro ROT_DEBOUNCE_STROBE_EN undefined: CTR_PRESS and CTR_RELEASE SHALL be constant 0, the edge-detect flop SHALL be omitted, and all other behaviour SHALL be unchanged.

Verification (DB_CYCLES=4, strobe macro defined unless stated)
REQ-026 Reset low, all raw inputs 0 -> ROT_A=1, ROT_B=1, ROT_CTR=0, strobes 0; after release, ROT_A and ROT_B fall on edge 6.
REQ-027 ROT_CTR_IN 0->1 held -> ROT_CTR rises on edge 6 with CTR_PRESS=1 for that single cycle; a later 1->0 transition gives CTR_RELEASE=1 for one cycle on edge 6.
REQ-028 ROT_A_IN low for 3 cycles, then high -> ROT_A stays 1 throughout; counter returns to 0.
REQ-029 Bounce ROT_CTR_IN 1,0,1,0,1 one cycle each, then hold 1 -> exactly one CTR_PRESS, timed 6 edges after the final 0->1 transition.
REQ-030 RST_N pulsed low while a ROT_B count is at 2 -> counter returns to 0; after release, ROT_B changes only after a full 6 edges.
REQ-031 Macro undefined, repeat REQ-027 -> ROT_CTR timing is identical and both strobes stay 0.
